// File: rtl/mac_acc_bias_if.sv
// Accumulator-to-bound handshake bundle: transaction start/bias, operand
// beat stream with backpressure, and the accumulator+bias result channel.
interface mac_acc_bias_if #(
  parameter int unsigned D_BW  = 8,
  parameter int unsigned AB_BW = 21,
  parameter int unsigned B_BW  = 16
);
  logic             i_start;
  logic [B_BW-1:0]  i_bias;
  logic             i_valid;
  logic [D_BW-1:0]  i_a;
  logic [D_BW-1:0]  i_b;
  logic             o_in_ready;
  logic             o_valid;
  logic             i_out_ready;
  logic [AB_BW-1:0] o_acc_bias;
  logic             o_busy;

  // Producer side: the MAC block itself.
  modport master (
    input  i_start, i_bias, i_valid, i_a, i_b, i_out_ready,
    output o_in_ready, o_valid, o_acc_bias, o_busy
  );

  // Consumer/driver side: operand source and the bound stage.
  modport slave (
    output i_start, i_bias, i_valid, i_a, i_b, i_out_ready,
    input  o_in_ready, o_valid, o_acc_bias, o_busy
  );
endinterface

// File: rtl/mac_acc_bias.sv
// Multiply-accumulate of ACC_LEN signed operand pairs onto a preloaded
// signed bias; the result is offered through a valid/ready handshake.
module mac_acc_bias #(
  parameter int unsigned D_BW    = 8,
  parameter int unsigned AB_BW   = 21,
  parameter int unsigned B_BW    = 16,
  parameter int unsigned ACC_LEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  mac_acc_bias_if.master bus
);

  localparam int unsigned CW = $clog2(ACC_LEN + 1);
  localparam int unsigned PW = 2 * D_BW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [AB_BW-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             valid_q;
  logic             busy_q;

  logic signed [PW-1:0] prod_d;
  logic [AB_BW-1:0]     prod_ext_d;
  logic [AB_BW-1:0]     bias_ext_d;

  // Full-width signed product and sign extensions of product and bias.
  always_comb begin
    prod_d     = $signed(bus.i_a) * $signed(bus.i_b);
    prod_ext_d = {{(AB_BW - PW){prod_d[PW-1]}}, prod_d};
    bias_ext_d = {{(AB_BW - B_BW){bus.i_bias[B_BW-1]}}, bus.i_bias};
  end

  // Transaction FSM with accumulator, beat counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            acc_q      <= bias_ext_d;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ACC;
          end
        end
        ACC: begin
          if (bus.i_valid) begin
            acc_q <= acc_q + prod_ext_d;
            if (cnt_q == CW'(ACC_LEN - 1)) begin
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              valid_q    <= 1'b1;
              state_q    <= OUT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        OUT: begin
          if (bus.i_out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_in_ready = in_ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_acc_bias = acc_q;

endmodule

// File: tb/tb_mac_acc_bias.sv
// Directed bench for mac_acc_bias: reset, basic, extremes, input gaps,
// output backpressure and mid-transaction reset.
module tb_mac_acc_bias;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mac_acc_bias_if #(.D_BW(8), .AB_BW(21), .B_BW(16)) bus ();

  mac_acc_bias #(.D_BW(8), .AB_BW(21), .B_BW(16), .ACC_LEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic signed [31:0] acc_exp);
    check({tag, "_valid"}, {31'd0, bus.o_valid}, 0);
    check({tag, "_in_ready"}, {31'd0, bus.o_in_ready}, 0);
    check({tag, "_busy"}, {31'd0, bus.o_busy}, 0);
    check({tag, "_acc"}, $signed(bus.o_acc_bias), acc_exp);
  endtask

  task automatic do_start(input string tag, input logic signed [15:0] bias);
    bus.i_start = 1'b1;
    bus.i_bias  = bias;
    tick();
    bus.i_start = 1'b0;
    check({tag, "_start_in_ready"}, {31'd0, bus.o_in_ready}, 1);
    check({tag, "_start_busy"}, {31'd0, bus.o_busy}, 1);
  endtask

  // Feeds beats until 32 are accepted; o_valid must appear exactly on the
  // cycle following the last accepted beat and not before.
  task automatic do_beats(input string tag, input logic signed [7:0] a,
                          input logic signed [7:0] b, input bit gap);
    int n = 0;
    int cyc = 0;
    bit early = 1'b0;
    while (n < 32 && cyc < 200) begin
      bus.i_valid = gap ? ((cyc % 2) == 0) : 1'b1;
      bus.i_a = a;
      bus.i_b = b;
      tick();
      if (bus.i_valid) n++;
      if (n < 32 && bus.o_valid) early = 1'b1;
      cyc++;
    end
    bus.i_valid = 1'b0;
    check({tag, "_beats_accepted"}, n, 32);
    check({tag, "_no_early_valid"}, {31'd0, early}, 0);
    check({tag, "_valid_after_last"}, {31'd0, bus.o_valid}, 1);
    check({tag, "_in_ready_out"}, {31'd0, bus.o_in_ready}, 0);
  endtask

  task automatic do_accept(input string tag);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
    check({tag, "_accept_valid"}, {31'd0, bus.o_valid}, 0);
    check({tag, "_accept_busy"}, {31'd0, bus.o_busy}, 0);
  endtask

  initial begin
    logic signed [31:0] held;
    bus.i_start = 1'b0;
    bus.i_bias = '0;
    bus.i_valid = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_out_ready = 1'b0;

    // Reset from an arbitrary mid-accumulation state.
    rst = 1'b0;
    tick();
    do_start("pre", 16'sd1234);
    bus.i_valid = 1'b1; bus.i_a = 8'sd9; bus.i_b = 8'sd7;
    tick(); tick(); tick();
    bus.i_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_idle("reset", 0);
    // Beat with no start is ignored.
    bus.i_valid = 1'b1; bus.i_a = 8'sd5; bus.i_b = 8'sd5;
    check("nostart_in_ready_now", {31'd0, bus.o_in_ready}, 0);
    tick();
    bus.i_valid = 1'b0;
    check_idle("nostart", 0);

    // Basic: -100 + 32*1 = -68.
    do_start("basic", -16'sd100);
    do_beats("basic", 8'sd1, 8'sd1, 1'b0);
    check("basic_acc", $signed(bus.o_acc_bias), -68);
    do_accept("basic");
    check("basic_hold_idle", $signed(bus.o_acc_bias), -68);

    // Extremes: 32767 + 32*16384 = 557055.
    do_start("ext1", 16'sd32767);
    do_beats("ext1", -8'sd128, -8'sd128, 1'b0);
    check("ext1_acc", $signed(bus.o_acc_bias), 557055);
    do_accept("ext1");

    // -32768 + 32*(-16256) = -552960.
    do_start("ext2", -16'sd32768);
    do_beats("ext2", -8'sd128, 8'sd127, 1'b0);
    check("ext2_acc", $signed(bus.o_acc_bias), -552960);
    do_accept("ext2");

    // Gaps: 0 + 32*(-6) = -192, then 5 cycles of backpressure.
    do_start("gap", 16'sd0);
    do_beats("gap", 8'sd3, -8'sd2, 1'b1);
    check("gap_acc", $signed(bus.o_acc_bias), -192);
    held = $signed(bus.o_acc_bias);
    for (int i = 0; i < 5; i++) begin
      bus.i_start = (i % 2) == 0;
      bus.i_bias = 16'sd77;
      tick();
      check("bp_valid", {31'd0, bus.o_valid}, 1);
      check("bp_acc_stable", $signed(bus.o_acc_bias), held);
      check("bp_in_ready", {31'd0, bus.o_in_ready}, 0);
    end
    // Start coincident with the accept is ignored.
    bus.i_start = 1'b1;
    do_accept("bp");
    bus.i_start = 1'b0;
    tick();
    check_idle("bp_start_ignored", -192);

    // Start right after accept is honored; then reset mid-op after 10 beats.
    do_accept("bp_dummy");
    do_start("mid", 16'sd100);
    bus.i_valid = 1'b1; bus.i_a = 8'sd4; bus.i_b = 8'sd4;
    for (int i = 0; i < 10; i++) tick();
    bus.i_valid = 1'b0;
    check("mid_partial_acc", $signed(bus.o_acc_bias), 260);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_reset", 0);

    // Clean run after abort: 5 + 32*6 = 197.
    do_start("post", 16'sd5);
    do_beats("post", 8'sd2, 8'sd3, 1'b0);
    check("post_acc", $signed(bus.o_acc_bias), 197);
    do_accept("post");
    do_start("next", 16'sd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
